imm_extend_unit: RTL and testbench
==================================

// Module: imm_extend_unit
// PURPOSE
//  RV32 immediate generator for the single-cycle/pipelined datapath decode stage.
//  - Takes instruction bits [31:7] plus a 2-bit immediate-format select from the main decoder.
//  - Produces the 32-bit sign-extended immediate in I, S, B or J format.
//  - The result is registered: one cycle of latency, with a valid flag alongside.
// PARAMETERS
//  REG_OUT  1  1 = registered output (1-cycle latency); 0 = purely combinational, clk/rst unused
// PORTS
//  clk      in   1   single clock, rising edge
//  rst      in   1   asynchronous, active-high reset
//  valid_i  in   1   instr/immsrc are valid this cycle
//  instr    in   25  instruction bits [31:7], declared as [31:7]
//  immsrc   in   2   format: 00=I, 01=S, 10=B, 11=J
//  valid_o  out  1   immext holds a freshly extended immediate
//  immext   out  32  sign-extended immediate
// BEHAVIOUR
//  Format decode (pure combinational, s = instr[31]):
//   I (00): {{20{s}}, instr[31:20]}
//   S (01): {{20{s}}, instr[31:25], instr[11:7]}
//   B (10): {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0}
//   J (11): {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0}
//  Encoding coverage: all four immsrc codes are legal; there is no default/X path.
//  B and J results are always even (bit0 = 0).
//  Reset: while rst=1, immext=32'h0 and valid_o=0, asynchronously.
//  REG_OUT=1, capture rule: on each rising clk edge with rst=0:
//   - valid_o <= valid_i
//   - immext  <= decode(instr, immsrc) only when valid_i=1; otherwise immext holds its value.
//  REG_OUT=1, latency: exactly 1 cycle from valid_i to valid_o.
//   - Back-to-back valid_i every cycle is supported; no stall or back-pressure.
//  REG_OUT=1, reset mid-stream: an in-flight result is dropped.
//   - The first output after rst deasserts corresponds to the first valid_i sampled after deassertion.
//  REG_OUT=0: immext = decode(...) combinationally; valid_o = valid_i.
//  Simultaneous rst and valid_i: reset wins; the input is discarded.
//  Width rule: output is always 32 bits; sign comes solely from instr[31].
// STRUCTURE
//  Shared package (imm_pkg):
//   - immsrc localparams IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11
//   - XLEN=32
//  Sub-module imm_decode: combinational case on immsrc.
//  Top level: optional output register plus valid flop, selected by a generate on REG_OUT.
// TESTING
//  I: instr=25'h1FFFFFF, immsrc=00 -> immext=32'hFFFFFFFF one cycle later, valid_o=1.
//  I: instr=25'b111100001111_0000111000110, immsrc=00 -> 32'hFFFFFF0F.
//  S: instr=25'b1010101010101010101010101, immsrc=01 -> 32'hFFFFFAB5.
//  B: instr=25'b0_101010_101010101010_1010_1_0, immsrc=10 -> 32'h0000054A.
//  J: instr=25'b1_1001100110_0_11001100_11001, immsrc=11 -> 32'hFFFCC4CC.
//  Reset/valid:
//   - Assert rst mid-stream -> immext=0 and valid_o=0 immediately.
//   - valid_i=0 -> immext holds its value and valid_o=0.
//   - Back-to-back I,S,B,J inputs -> results appear in order, one per cycle.

Source files
------------

// File: rtl/imm_extend_unit_pkg.sv
// Shared definitions for the RV32 immediate generator.
//   XLEN            : datapath width
//   IMM_I..IMM_J    : immediate-format select codes driven by the main decoder
package imm_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Request/response bundle between the decode stage and the immediate generator.
//   valid_i : instr/immsrc are valid this cycle
//   instr   : instruction bits [31:7]
//   immsrc  : immediate format select
//   valid_o : immext holds a freshly extended immediate
//   immext  : sign-extended immediate
// master = decode stage driving the request, slave = immediate generator.
interface imm_extend_unit_if;
    import imm_pkg::*;

    logic            valid_i;
    logic [31:7]     instr;
    logic [1:0]      immsrc;
    logic            valid_o;
    logic [XLEN-1:0] immext;

    modport master (output valid_i, output instr, output immsrc,
                    input  valid_o, input  immext);
    modport slave  (input  valid_i, input  instr, input  immsrc,
                    output valid_o, output immext);
endinterface

// File: rtl/imm_extend_unit_decode.sv
// Combinational RV32 immediate format decode.
//   instr  : instruction bits [31:7]
//   immsrc : format select (I, S, B, J)
//   imm    : sign-extended 32-bit immediate; sign is always instr[31]
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:7]     instr,
    input  logic [1:0]      immsrc,
    output logic [XLEN-1:0] imm
);

    logic s;
    assign s = instr[31];

    always_comb begin
        imm = '0;
        case (immsrc)
            IMM_I: imm = {{20{s}}, instr[31:20]};
            IMM_S: imm = {{20{s}}, instr[31:25], instr[11:7]};
            // B and J scramble the offset bits and drop bit 0 (always even)
            IMM_B: imm = {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// RV32 immediate generator for the decode stage.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of imm_extend_unit_if (valid_i/instr/immsrc in,
//              valid_o/immext out)
// REG_OUT=1 registers the result (1-cycle latency, immext holds when no new
// valid input); REG_OUT=0 is purely combinational and ignores clk/rst.
module imm_extend_unit
    import imm_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    imm_extend_unit_if.slave  bus
);

    logic [XLEN-1:0] imm_dec;

    imm_decode u_dec (
        .instr  (bus.instr),
        .immsrc (bus.immsrc),
        .imm    (imm_dec)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic            valid_q;
            logic [XLEN-1:0] imm_q;

            // Reset wins over a coincident valid_i, so in-flight data is dropped.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    imm_q   <= '0;
                end else begin
                    valid_q <= bus.valid_i;
                    if (bus.valid_i)
                        imm_q <= imm_dec;
                end
            end

            assign bus.valid_o = valid_q;
            assign bus.immext  = imm_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};

            assign bus.valid_o = bus.valid_i;
            assign bus.immext  = imm_dec;
        end
    endgenerate

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: registered instance plus a
// combinational (REG_OUT=0) instance fed the same stimulus.
module tb_imm_extend_unit;

    logic clk;
    logic rst;

    imm_extend_unit_if bus ();
    imm_extend_unit_if bus_c ();

    imm_extend_unit #(.REG_OUT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    imm_extend_unit #(.REG_OUT(1'b0)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] instr;
        logic [1:0]  src;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [24:0] ins, input logic [1:0] src);
        bus.valid_i   = v;
        bus.instr     = ins;
        bus.immsrc    = src;
        bus_c.valid_i = v;
        bus_c.instr   = ins;
        bus_c.immsrc  = src;
    endtask

    initial begin
        vecs[0]  = '{25'h1FFFFFF,                          2'b00, 32'hFFFFFFFF};
        vecs[1]  = '{25'b111100001111_0000111000110,       2'b00, 32'hFFFFFF0F};
        vecs[2]  = '{25'b1010101010101010101010101,        2'b01, 32'hFFFFFAB5};
        vecs[3]  = '{25'b0_101010_101010101010_1010_1_0,   2'b10, 32'h0000054A};
        vecs[4]  = '{25'b1_1001100110_0_11001100_11001,    2'b11, 32'hFFFCC4CC};
        // positive-sign pattern {12'h123, 13'h0} in every format
        vecs[5]  = '{{12'h123, 13'h0},                     2'b00, 32'h00000123};
        vecs[6]  = '{{12'h123, 13'h0},                     2'b01, 32'h00000120};
        vecs[7]  = '{{12'h123, 13'h0},                     2'b10, 32'h00000120};
        vecs[8]  = '{{12'h123, 13'h0},                     2'b11, 32'h00000922};
        // sign bit alone: extension reaches exactly the format's top bit
        vecs[9]  = '{25'h1000000,                          2'b00, 32'hFFFFF800};
        vecs[10] = '{25'h1000000,                          2'b01, 32'hFFFFF800};
        vecs[11] = '{25'h1000000,                          2'b10, 32'hFFFFF000};
        vecs[12] = '{25'h1000000,                          2'b11, 32'hFFF00000};

        rst = 1'b1;
        drive(1'b0, '0, 2'b00);
        #1;
        check("reset_immext", bus.immext, 32'h0);
        check("reset_valid",  {31'b0, bus.valid_o}, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // back-to-back stream: one vector per cycle, result one cycle later
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].instr, vecs[i].src);
            #1;
            check($sformatf("comb_imm[%0d]", i), bus_c.immext, vecs[i].exp);
            check($sformatf("comb_vld[%0d]", i), {31'b0, bus_c.valid_o}, 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("reg_vld[%0d]", i), {31'b0, bus.valid_o}, 32'h1);
            check($sformatf("reg_imm[%0d]", i), bus.immext, vecs[i].exp);
        end

        // valid_i low: immext holds the last result, valid_o drops
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 25'h0AAAAAA, 2'b00);
            @(posedge clk);
            #1;
            check("hold_valid",  {31'b0, bus.valid_o}, 32'h0);
            check("hold_immext", bus.immext, vecs[NV-1].exp);
        end

        // reset mid-stream
        @(negedge clk);
        drive(1'b1, vecs[0].instr, vecs[0].src);
        @(posedge clk);
        #1;
        check("pre_rst_imm", bus.immext, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1'b1, vecs[4].instr, vecs[4].src);
        #2 rst = 1'b1;
        #1;
        check("async_rst_imm", bus.immext, 32'h0);
        check("async_rst_vld", {31'b0, bus.valid_o}, 32'h0);
        // rst and valid_i together at an edge: reset wins
        @(posedge clk);
        #1;
        check("rst_wins_imm", bus.immext, 32'h0);
        check("rst_wins_vld", {31'b0, bus.valid_o}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, vecs[4].instr, vecs[4].src);
        @(posedge clk);
        #1;
        check("post_rst_vld", {31'b0, bus.valid_o}, 32'h0);
        check("post_rst_imm", bus.immext, 32'h0);

        // first valid after reset is the first output
        @(negedge clk);
        drive(1'b1, vecs[2].instr, vecs[2].src);
        @(posedge clk);
        #1;
        check("first_after_rst_vld", {31'b0, bus.valid_o}, 32'h1);
        check("first_after_rst_imm", bus.immext, 32'hFFFFFAB5);

        @(negedge clk);
        drive(1'b0, '0, 2'b00);
        @(posedge clk);
        #1;
        check("tail_vld", {31'b0, bus.valid_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
